ndro_pulse_monitor: RTL and testbench

Synthesizable cycle-sampled monitor for a basic NDRO cell: it observes the cell's set, reset and clk stimulus and its out response, where each transition represents one SFQ pulse. It maintains a reference model of the stored bit, predicts out pulses, and flags setup, hold, conflict, spurious and missing-pulse errors. It sits beside the device under test in NDRO testbenches, so a dumped VCD carries explicit error markers for vcd_assert checks.

---
 rtl/ndro_pulse_monitor.sv | 126 ++++++++++++
 tb/tb_ndro_pulse_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ndro_pulse_monitor.sv
// rtl/ndro_pulse_monitor.sv - cycle-sampled NDRO cell monitor with reference model and error strobes
// Optional viol_count saturating counter enabled by NDRO_MONITOR_COUNT_EN.
module ndro_pulse_monitor #(
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 3,
  parameter int OUT_LAT_MAX = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ndro_set,
  input  logic             ndro_reset,
  input  logic             ndro_clk,
  input  logic             ndro_out,
  output logic             state_q,
  output logic             err_setup,
  output logic             err_hold,
  output logic             err_conflict,
  output logic             err_spurious,
  output logic             err_missing,
  output logic             err_any,
  output logic [CNT_W-1:0] viol_count
);

  localparam int SW = $clog2(SETUP_CYC + 2);
  localparam int HW = $clog2(HOLD_CYC + 2);
  localparam int AW = $clog2(OUT_LAT_MAX + 1);
  localparam logic [SW-1:0] SETUP_LIM = SW'(SETUP_CYC);
  localparam logic [SW-1:0] SETUP_SAT = SW'(SETUP_CYC + 1);
  localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD_CYC);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYC + 1);
  localparam logic [AW-1:0] AGE_LIM   = AW'(OUT_LAT_MAX);

  logic          set_d, reset_d, clk_d, out_d;
  logic [SW-1:0] since_sr;
  logic [HW-1:0] since_clk;
  logic          exp_armed;
  logic [AW-1:0] exp_age;

  logic set_p, rst_p, clk_p, out_p, sr_p;
  logic setup_n, hold_n, conflict_n, spurious_n, missing_n;

  // since_* hold the distance from the last pulse strictly before this cycle.
  always_comb begin
    set_p      = ndro_set ^ set_d;
    rst_p      = ndro_reset ^ reset_d;
    clk_p      = ndro_clk ^ clk_d;
    out_p      = ndro_out ^ out_d;
    sr_p       = set_p | rst_p;
    setup_n    = clk_p && (sr_p || (since_sr <= SETUP_LIM));
    hold_n     = sr_p && !clk_p && (since_clk <= HOLD_LIM);
    conflict_n = set_p && rst_p;
    spurious_n = out_p && !exp_armed;
    missing_n  = exp_armed && !out_p && (clk_p || (exp_age == AGE_LIM));
  end

  always_ff @(posedge clk) begin
    set_d   <= ndro_set;
    reset_d <= ndro_reset;
    clk_d   <= ndro_clk;
    out_d   <= ndro_out;
    if (reset) begin
      state_q      <= 1'b0;
      err_setup    <= 1'b0;
      err_hold     <= 1'b0;
      err_conflict <= 1'b0;
      err_spurious <= 1'b0;
      err_missing  <= 1'b0;
      err_any      <= 1'b0;
      since_sr     <= SETUP_SAT;
      since_clk    <= HOLD_SAT;
      exp_armed    <= 1'b0;
      exp_age      <= '0;
    end else begin
      if (set_p && !rst_p)
        state_q <= 1'b1;
      else if (rst_p && !set_p)
        state_q <= 1'b0;
      err_setup    <= setup_n;
      err_hold     <= hold_n;
      err_conflict <= conflict_n;
      err_spurious <= spurious_n;
      err_missing  <= missing_n;
      err_any      <= err_any | setup_n | hold_n | conflict_n | spurious_n | missing_n;
      if (sr_p)
        since_sr <= SW'(1);
      else if (since_sr != SETUP_SAT)
        since_sr <= since_sr + 1'b1;
      if (clk_p)
        since_clk <= HW'(1);
      else if (since_clk != HOLD_SAT)
        since_clk <= since_clk + 1'b1;
      // A clk pulse samples the pre-update state and replaces any older window.
      if (clk_p) begin
        exp_armed <= state_q;
        exp_age   <= AW'(1);
      end else if (exp_armed && (out_p || missing_n)) begin
        exp_armed <= 1'b0;
      end else if (exp_armed) begin
        exp_age <= exp_age + 1'b1;
      end
    end
  end

`ifdef NDRO_MONITOR_COUNT_EN
  logic [2:0]       n_err;
  logic [CNT_W+2:0] cnt_sum;

  always_comb begin
    n_err   = 3'(setup_n) + 3'(hold_n) + 3'(conflict_n) + 3'(spurious_n) + 3'(missing_n);
    cnt_sum = (CNT_W+3)'(viol_count) + (CNT_W+3)'(n_err);
  end

  always_ff @(posedge clk) begin
    if (reset)
      viol_count <= '0;
    else if (cnt_sum[CNT_W+2:CNT_W] != 3'b000)
      viol_count <= '1;
    else
      viol_count <= cnt_sum[CNT_W-1:0];
  end
`else
  assign viol_count = '0;
`endif

endmodule

// File: tb/tb_ndro_pulse_monitor.sv
// tb/tb_ndro_pulse_monitor.sv - scoreboard bench for ndro_pulse_monitor
module tb_ndro_pulse_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ndro_set = 1'b0;
  logic        ndro_reset = 1'b0;
  logic        ndro_clk = 1'b0;
  logic        ndro_out = 1'b0;
  logic        state_q;
  logic        err_setup, err_hold, err_conflict, err_spurious, err_missing, err_any;
  logic [15:0] viol_count;

  ndro_pulse_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .ndro_set     (ndro_set),
    .ndro_reset   (ndro_reset),
    .ndro_clk     (ndro_clk),
    .ndro_out     (ndro_out),
    .state_q      (state_q),
    .err_setup    (err_setup),
    .err_hold     (err_hold),
    .err_conflict (err_conflict),
    .err_spurious (err_spurious),
    .err_missing  (err_missing),
    .err_any      (err_any),
    .viol_count   (viol_count)
  );

  always #5 clk = ~clk;

  // cyc = index of the most recent sampling edge since reset release
  int cyc = 0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  localparam logic [4:0] M_SETUP = 5'b10000;
  localparam logic [4:0] M_HOLD  = 5'b01000;
  localparam logic [4:0] M_CONF  = 5'b00100;
  localparam logic [4:0] M_SPUR  = 5'b00010;
  localparam logic [4:0] M_MISS  = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_cnt = 0;
  int   model_any = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_strobe(input int c, input logic [4:0] m);
    exp_q.push_back('{cyc: c, mask: m});
  endtask

  // Leaves us at the negedge just before sampling edge c.
  task automatic at(input int c);
    while (cyc < c - 1) @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: strobes visible after edge cyc belong to cycle cyc+1.
  logic [4:0] mon_mask;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      mon_mask = {err_setup, err_hold, err_conflict, err_spurious, err_missing};
      if (mon_mask != 5'b0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got mask %b at cycle %0d required none", mon_mask, cyc + 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_cycle", cyc + 1, mon_e.cyc);
          check("strobe_mask", int'(mon_mask), int'(mon_e.mask));
          model_any = 1;
`ifdef NDRO_MONITOR_COUNT_EN
          model_cnt = model_cnt + $countones(mon_e.mask);
          if (model_cnt > 65535) model_cnt = 65535;
`endif
          check("err_any", int'(err_any), model_any);
          check("viol_count", int'(viol_count), model_cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state_q", int'(state_q), 0);
    check("rst_err_any", int'(err_any), 0);
    check("rst_viol_count", int'(viol_count), 0);
    check("rst_strobes", int'({err_setup, err_hold, err_conflict, err_spurious, err_missing}), 0);
    reset = 1'b0;

    // clean set, read, out
    at(10); ndro_set = ~ndro_set;
    wait_cyc(9);  check("s1_state_before", int'(state_q), 0);
    wait_cyc(10); check("s1_state_after", int'(state_q), 1);
    at(20); ndro_clk = ~ndro_clk;
    at(22); ndro_out = ~ndro_out;

    // hold violation at distance 2, then missing out for the clk at 30
    at(30); ndro_clk = ~ndro_clk;
    at(32); ndro_reset = ~ndro_reset;
    expect_strobe(33, M_HOLD);
    expect_strobe(35, M_MISS);
    wait_cyc(32); check("s2_state", int'(state_q), 0);

    // same-cycle set+clk: setup only, samples pre-update 0, out is spurious
    at(40); ndro_set = ~ndro_set; ndro_clk = ~ndro_clk;
    expect_strobe(41, M_SETUP);
    at(42); ndro_out = ~ndro_out;
    expect_strobe(43, M_SPUR);
    wait_cyc(40); check("s3_state", int'(state_q), 1);

    // setup at distance SETUP_CYC; out in the arming cycle is spurious; window expires
    at(50); ndro_set = ~ndro_set;
    at(52); ndro_clk = ~ndro_clk; ndro_out = ~ndro_out;
    expect_strobe(53, M_SETUP | M_SPUR);
    expect_strobe(57, M_MISS);

    // setup distance 3 is clean; out at the last window cycle is accepted
    at(60); ndro_set = ~ndro_set;
    at(63); ndro_clk = ~ndro_clk;
    at(67); ndro_out = ~ndro_out;

    // hold distance 4 clean, hold distance 3 flagged
    at(70); ndro_clk = ~ndro_clk;
    at(71); ndro_out = ~ndro_out;
    at(74); ndro_reset = ~ndro_reset;
    at(80); ndro_clk = ~ndro_clk;
    at(83); ndro_set = ~ndro_set;
    expect_strobe(84, M_HOLD);
    wait_cyc(74); check("s6_state_reset", int'(state_q), 0);
    wait_cyc(83); check("s6_state_set", int'(state_q), 1);

    // conflict leaves the state unchanged
    at(90); ndro_set = ~ndro_set; ndro_reset = ~ndro_reset;
    expect_strobe(91, M_CONF);
    wait_cyc(91); check("s7_state", int'(state_q), 1);

    // second clk while armed: missing for the old window, re-armed window met
    at(100); ndro_clk = ~ndro_clk;
    at(102); ndro_clk = ~ndro_clk;
    expect_strobe(103, M_MISS);
    at(104); ndro_out = ~ndro_out;

    // out one cycle too late: missing, then spurious
    at(110); ndro_clk = ~ndro_clk;
    at(115); ndro_out = ~ndro_out;
    expect_strobe(115, M_MISS);
    expect_strobe(116, M_SPUR);

    // three strobes in one cycle
    at(120); ndro_set = ~ndro_set; ndro_reset = ~ndro_reset; ndro_clk = ~ndro_clk; ndro_out = ~ndro_out;
    expect_strobe(121, M_SETUP | M_CONF | M_SPUR);
    expect_strobe(125, M_MISS);

    // reset mid-window discards the expectation and history
    at(130); ndro_clk = ~ndro_clk;
    wait_cyc(128); check("s10_err_any", int'(err_any), 1);
    at(132);
    check("pre_reset_queue", exp_q.size(), 0);
    reset = 1'b1;
    ndro_clk = ~ndro_clk;
    repeat (2) @(negedge clk);
    check("mid_rst_state_q", int'(state_q), 0);
    check("mid_rst_err_any", int'(err_any), 0);
    check("mid_rst_viol_count", int'(viol_count), 0);
    model_cnt = 0;
    model_any = 0;
    reset = 1'b0;
    at(2); ndro_set = ~ndro_set;
    wait_cyc(2); check("post_rst_state", int'(state_q), 1);
    wait_cyc(12);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_err_any", int'(err_any), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
